// File: rtl/glitch_monitor_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : glitch_monitor_seq
// Description : Multi-channel TDL glitch monitor. During an armed window of
//               programmable length it tracks, for every channel, the minimum
//               ones-count, a saturating hit counter and the first-hit
//               timestamp. After the window it streams a framed byte report
//               that ends in an XOR checksum, over a valid/ready byte port.
//
// Ports       : clk         - single clock (TDL capture domain)
//               rstn        - asynchronous active-low reset
//               cnt_in      - NCH ones-counts, channel k at [k*CNT_W +: CNT_W]
//               cnt_valid   - cnt_in valid this cycle
//               thresh      - shared glitch threshold, sampled live
//               win_len     - window length in cycles, latched on arm
//               arm         - start-window pulse (only honoured in IDLE)
//               abort       - end the window early (only honoured in MON)
//               glitch_live - per-channel hit flag, one cycle after the sample
//               busy        - high whenever the monitor is not idle
//               done        - one-cycle pulse after the last report byte
//               byte_data   - report byte
//               byte_valid  - byte_data valid
//               byte_ready  - consumer accepts the byte
//
// Revision    : 1.0 - initial release
// ============================================================================
module glitch_monitor_seq #(
    parameter int NCH   = 4,
    parameter int CNT_W = 7,
    parameter int EVT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCH*CNT_W-1:0] cnt_in,
    input  logic                 cnt_valid,
    input  logic [CNT_W-1:0]     thresh,
    input  logic [TS_W-1:0]      win_len,
    input  logic                 arm,
    input  logic                 abort,
    output logic [NCH-1:0]       glitch_live,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int EVT_B = EVT_W / 8;            // event counter bytes
    localparam int TS_B  = TS_W / 8;             // timestamp bytes
    localparam int BPC   = 2 + EVT_B + TS_B;     // report bytes per channel
    localparam int SUB_W = $clog2(BPC);          // BPC >= 4, so SUB_W >= 2
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MON    = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    // Report segment: header byte, per-channel body, checksum trailer
    localparam logic [1:0] SEG_HDR  = 2'd0;
    localparam logic [1:0] SEG_BODY = 2'd1;
    localparam logic [1:0] SEG_TRL  = 2'd2;

    localparam logic [7:0] HDR_NORMAL  = 8'hA5;
    localparam logic [7:0] HDR_ABORTED = 8'h5A;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]       state_q;
    logic [1:0]       state_d;

    logic [TS_W-1:0]  win_cnt_q;
    logic [TS_W-1:0]  tcnt_q;
    logic             aborted_q;

    logic [NCH-1:0]   glitch_q;
    logic [1:0]       seg_q;
    logic [CH_W-1:0]  ch_q;
    logic [SUB_W-1:0] sub_q;
    logic [7:0]       chk_q;
    logic             done_q;

    // Per-channel statistics, gathered from the g_ch generate block
    logic [CNT_W-1:0] w_min [NCH];
    logic [EVT_W-1:0] w_evt [NCH];
    logic [TS_W-1:0]  w_ts  [NCH];
    logic [NCH-1:0]   w_ovf;
    logic [NCH-1:0]   w_hitf;
    logic [NCH-1:0]   w_hit;

    logic             w_arm_go;
    logic             w_mon;
    logic             w_xfer;
    logic [7:0]       w_body;

    assign w_arm_go = (state_q == S_IDLE) && arm;
    assign w_mon    = (state_q == S_MON);
    assign w_xfer   = byte_valid && byte_ready;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_MON;
                end
            end
            S_MON: begin
                // win_cnt_q == 1 marks the last sample cycle of the window
                if (abort || (win_cnt_q == TS_W'(1))) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (w_xfer && (seg_q == SEG_TRL)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    always_comb begin
        busy        = (state_q != S_IDLE);
        byte_valid  = (state_q == S_REPORT);
        done        = done_q;
        glitch_live = w_mon ? glitch_q : '0;
        byte_data   = 8'h00;
        if (state_q == S_REPORT) begin
            case (seg_q)
                SEG_HDR:  byte_data = aborted_q ? HDR_ABORTED : HDR_NORMAL;
                SEG_BODY: byte_data = w_body;
                SEG_TRL:  byte_data = chk_q;
                default:  byte_data = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Window length / timestamp counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_cnt_q <= TS_W'(1);
            tcnt_q    <= '0;
            aborted_q <= 1'b0;
        end else if (w_arm_go) begin
            // A zero length still gives a one-sample window
            win_cnt_q <= (win_len == '0) ? TS_W'(1) : win_len;
            tcnt_q    <= '0;
            aborted_q <= 1'b0;
        end else if (w_mon) begin
            tcnt_q    <= tcnt_q + TS_W'(1);
            win_cnt_q <= win_cnt_q - TS_W'(1);
            if (abort) begin
                aborted_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel statistics
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CNT_W-1:0] w_cnt;
        logic [CNT_W-1:0] min_q;
        logic [EVT_W-1:0] evt_q;
        logic [TS_W-1:0]  ts_q;
        logic             ovf_q;
        logic             hit_q;

        assign w_cnt    = cnt_in[k*CNT_W +: CNT_W];
        assign w_hit[k] = w_mon && cnt_valid && (w_cnt <= thresh);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                min_q <= '1;
                evt_q <= '0;
                ovf_q <= 1'b0;
                hit_q <= 1'b0;
                ts_q  <= '1;
            end else if (w_arm_go) begin
                min_q <= '1;
                evt_q <= '0;
                ovf_q <= 1'b0;
                hit_q <= 1'b0;
                ts_q  <= '1;
            end else if (w_mon && cnt_valid) begin
                if (w_cnt < min_q) begin
                    min_q <= w_cnt;
                end
                if (w_hit[k]) begin
                    // Saturate the counter; a hit that would wrap flags overflow
                    if (&evt_q) begin
                        ovf_q <= 1'b1;
                    end else begin
                        evt_q <= evt_q + EVT_W'(1);
                    end
                    if (!hit_q) begin
                        ts_q  <= tcnt_q;
                        hit_q <= 1'b1;
                    end
                end
            end
        end

        assign w_min[k]  = min_q;
        assign w_evt[k]  = evt_q;
        assign w_ts[k]   = ts_q;
        assign w_ovf[k]  = ovf_q;
        assign w_hitf[k] = hit_q;
    end

    // Live hit flags: the hit condition delayed by one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= w_hit;
        end
    end

    // ------------------------------------------------------------------------
    // Report sequencer. seg/ch/sub point at the byte currently presented;
    // they only move on a completed transfer, which keeps byte_data stable
    // under backpressure. chk_q accumulates every transferred byte so the
    // trailer is the XOR of everything before it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_q  <= SEG_HDR;
            ch_q   <= '0;
            sub_q  <= '0;
            chk_q  <= 8'h00;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_REPORT) && w_xfer && (seg_q == SEG_TRL);
            if (state_q != S_REPORT) begin
                seg_q <= SEG_HDR;
                ch_q  <= '0;
                sub_q <= '0;
                chk_q <= 8'h00;
            end else if (w_xfer) begin
                chk_q <= chk_q ^ byte_data;
                case (seg_q)
                    SEG_HDR: begin
                        seg_q <= SEG_BODY;
                    end
                    SEG_BODY: begin
                        if (sub_q == SUB_W'(BPC - 1)) begin
                            sub_q <= '0;
                            if (ch_q == CH_W'(NCH - 1)) begin
                                seg_q <= SEG_TRL;
                            end else begin
                                ch_q <= ch_q + CH_W'(1);
                            end
                        end else begin
                            sub_q <= sub_q + SUB_W'(1);
                        end
                    end
                    default: begin
                        seg_q <= seg_q;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Channel body byte select: status, min, evt (MSB first), ts (MSB first)
    // ------------------------------------------------------------------------
    always_comb begin
        w_body = 8'h00;
        if (sub_q == '0) begin
            w_body = {w_hitf[ch_q], w_ovf[ch_q], 6'b000000};
        end else if (sub_q == SUB_W'(1)) begin
            w_body = 8'(w_min[ch_q]);
        end
        for (int b = 0; b < EVT_B; b++) begin
            if (sub_q == SUB_W'(2 + b)) begin
                w_body = w_evt[ch_q][8*(EVT_B-1-b) +: 8];
            end
        end
        for (int b = 0; b < TS_B; b++) begin
            if (sub_q == SUB_W'(2 + EVT_B + b)) begin
                w_body = w_ts[ch_q][8*(TS_B-1-b) +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_glitch_monitor_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_glitch_monitor_seq
// Description : Self-checking bench for glitch_monitor_seq (NCH=2, CNT_W=7,
//               EVT_W=8, TS_W=16). Each window's samples are generated up
//               front; the expected report is derived from them directly
//               (minimum, hit count, first-hit index) and compared byte by
//               byte while the consumer applies backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glitch_monitor_seq;

    localparam int NCH    = 2;
    localparam int CNT_W  = 7;
    localparam int EVT_W  = 8;
    localparam int TS_W   = 16;
    localparam int NBYTES = 2 + NCH * (2 + EVT_W / 8 + TS_W / 8);
    localparam int MAXS   = 320;

    logic                 clk;
    logic                 rstn;
    logic [NCH*CNT_W-1:0] cnt_in;
    logic                 cnt_valid;
    logic [CNT_W-1:0]     thresh;
    logic [TS_W-1:0]      win_len;
    logic                 arm;
    logic                 abort;
    logic [NCH-1:0]       glitch_live;
    logic                 busy;
    logic                 done;
    logic [7:0]           byte_data;
    logic                 byte_valid;
    logic                 byte_ready;

    glitch_monitor_seq #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .EVT_W (EVT_W),
        .TS_W  (TS_W)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .cnt_in      (cnt_in),
        .cnt_valid   (cnt_valid),
        .thresh      (thresh),
        .win_len     (win_len),
        .arm         (arm),
        .abort       (abort),
        .glitch_live (glitch_live),
        .busy        (busy),
        .done        (done),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Window description and reference model
    // ------------------------------------------------------------------------
    int         s_cnt [NCH][MAXS];
    int         s_th  [MAXS];
    bit         s_val [MAXS];
    int         s_len;
    int         s_abort_at;
    int         s_ready_mode;   // 0: always ready, 1: random, 2: 1-0-0-1
    logic [7:0] exp_q [$];

    function automatic int win_cycles();
        return (s_len == 0) ? 1 : s_len;
    endfunction

    function automatic bit is_aborted();
        return (s_abort_at >= 0) && (s_abort_at < win_cycles());
    endfunction

    function automatic int n_samples();
        return is_aborted() ? s_abort_at + 1 : win_cycles();
    endfunction

    function automatic bit sample_hit(input int ch, input int i);
        return s_val[i] && (s_cnt[ch][i] <= s_th[i]);
    endfunction

    task automatic build_expect();
        logic [7:0]  x;
        logic [15:0] tsv;
        int          n;
        n = n_samples();
        exp_q.delete();
        exp_q.push_back(is_aborted() ? 8'h5A : 8'hA5);
        for (int ch = 0; ch < NCH; ch++) begin
            int mn;
            int hits;
            int first;
            mn    = 127;
            hits  = 0;
            first = -1;
            for (int i = 0; i < n; i++) begin
                if (s_val[i]) begin
                    if (s_cnt[ch][i] < mn) mn = s_cnt[ch][i];
                    if (sample_hit(ch, i)) begin
                        hits++;
                        if (first < 0) first = i;
                    end
                end
            end
            tsv = (first < 0) ? 16'hFFFF : 16'(first);
            exp_q.push_back({(first >= 0), (hits > 255), 6'b000000});
            exp_q.push_back(8'(mn));
            exp_q.push_back((hits > 255) ? 8'hFF : 8'(hits));
            exp_q.push_back(tsv[15:8]);
            exp_q.push_back(tsv[7:0]);
        end
        x = 8'h00;
        foreach (exp_q[j]) x = x ^ exp_q[j];
        exp_q.push_back(x);
    endtask

    task automatic fill_const(input int len, input int c0, input int c1, input int th);
        s_len        = len;
        s_abort_at   = -1;
        s_ready_mode = 0;
        for (int i = 0; i < MAXS; i++) begin
            s_val[i] = 1'b1;
            s_th[i]  = th;
            for (int ch = 0; ch < NCH; ch++) s_cnt[ch][i] = (ch == 0) ? c0 : c1;
        end
    endtask

    task automatic fill_random();
        s_len        = $urandom_range(0, 40);
        s_abort_at   = (($urandom % 4) == 0) ? $urandom_range(0, 40) : -1;
        s_ready_mode = 1;
        for (int i = 0; i < MAXS; i++) begin
            s_val[i] = ($urandom % 10) < 7;
            s_th[i]  = $urandom_range(0, 40);
            for (int ch = 0; ch < NCH; ch++)
                s_cnt[ch][i] = (($urandom % 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 127);
        end
    endtask

    // ------------------------------------------------------------------------
    // Run one window plus its report. rst_at >= 0 pulls rstn low when that
    // many bytes have been transferred and checks the immediate reset state.
    // ------------------------------------------------------------------------
    task automatic run_window(input string nm, input int rst_at);
        int             n;
        int             idx;
        int             budget;
        bit             stalled;
        bit             r;
        logic [7:0]     prev;
        logic [NCH-1:0] g_exp;

        n = n_samples();
        build_expect();

        @(negedge clk);
        check_eq({nm, "/idle_busy"}, busy, 0);
        win_len    = TS_W'(s_len);
        arm        = 1'b1;
        abort      = 1'b0;
        cnt_valid  = 1'b0;
        byte_ready = 1'b0;

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            g_exp = '0;
            if (i > 0) for (int ch = 0; ch < NCH; ch++) g_exp[ch] = sample_hit(ch, i - 1);
            check_eq({nm, "/glitch_live"}, glitch_live, g_exp);
            check_eq({nm, "/busy_mon"}, busy, 1);
            check_eq({nm, "/valid_mon"}, byte_valid, 0);
            arm       = (($urandom % 8) == 0);
            abort     = (i == s_abort_at);
            cnt_valid = s_val[i];
            thresh    = CNT_W'(s_th[i]);
            for (int ch = 0; ch < NCH; ch++) cnt_in[ch*CNT_W +: CNT_W] = CNT_W'(s_cnt[ch][i]);
        end

        idx     = 0;
        budget  = 0;
        stalled = 1'b0;
        prev    = 8'h00;
        while (idx < NBYTES && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (rst_at >= 0 && idx == rst_at) begin
                rstn = 1'b0;
                #1;
                check_eq({nm, "/rst_valid"}, byte_valid, 0);
                check_eq({nm, "/rst_data"}, byte_data, 0);
                check_eq({nm, "/rst_busy"}, busy, 0);
                check_eq({nm, "/rst_done"}, done, 0);
                check_eq({nm, "/rst_glitch"}, glitch_live, 0);
                arm        = 1'b0;
                abort      = 1'b0;
                byte_ready = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            check_eq({nm, "/valid_rep"}, byte_valid, 1);
            check_eq({nm, "/glitch_rep"}, glitch_live, 0);
            if (stalled) check_eq({nm, "/hold"}, byte_data, prev);
            cnt_valid = 1'b0;
            abort     = (($urandom % 4) == 0);
            arm       = (($urandom % 4) == 0);
            case (s_ready_mode)
                0:       r = 1'b1;
                1:       r = ($urandom % 2) == 1;
                default: r = (((budget - 1) % 4) == 0) || (((budget - 1) % 4) == 3);
            endcase
            byte_ready = r;
            if (byte_valid && r) begin
                check_eq({nm, "/byte"}, byte_data, exp_q[idx]);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = byte_valid;
                prev    = byte_data;
            end
        end

        if (idx < NBYTES) begin
            check_eq({nm, "/timeout_bytes"}, idx, NBYTES);
        end else begin
            @(negedge clk);
            check_eq({nm, "/done"}, done, 1);
            check_eq({nm, "/busy_done"}, busy, 0);
            check_eq({nm, "/valid_done"}, byte_valid, 0);
            check_eq({nm, "/data_done"}, byte_data, 0);
            arm        = 1'b0;
            abort      = 1'b0;
            byte_ready = 1'b0;
            @(negedge clk);
            check_eq({nm, "/done_once"}, done, 0);
        end
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        rstn       = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        cnt_valid  = 1'b0;
        cnt_in     = '0;
        thresh     = '0;
        win_len    = '0;
        byte_ready = 1'b0;
        #12;
        check_eq("reset/busy", busy, 0);
        check_eq("reset/done", done, 0);
        check_eq("reset/valid", byte_valid, 0);
        check_eq("reset/data", byte_data, 0);
        check_eq("reset/glitch", glitch_live, 0);
        @(negedge clk);
        rstn = 1'b1;

        fill_const(10, 40, 40, 15);
        run_window("noglitch", -1);

        fill_const(10, 40, 40, 15);
        s_cnt[1][3] = 12;
        run_window("single", -1);

        fill_const(300, 5, 40, 15);
        run_window("saturate", -1);

        fill_const(10, 40, 40, 15);
        s_abort_at  = 4;
        s_cnt[0][4] = 10;
        run_window("abort", -1);

        fill_random();
        s_ready_mode = 2;
        run_window("backpressure", -1);

        for (int t = 0; t < 12; t++) begin
            fill_random();
            run_window($sformatf("rand%0d", t), -1);
        end

        fill_random();
        s_abort_at = -1;
        run_window("midrst", 5);

        fill_random();
        run_window("after_rst", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
